alu_writeback: RTL and testbench

Writeback stage that sits directly downstream of the 32-bit ALU and consumes its 64-bit `reg_C` result. It buffers results in a 2-entry FIFO, retires MUL/DIV results into the HI/LO special registers, and drives all other results onto the register-file write port with a write/acknowledge handshake. Register 0 is hard-wired to zero, so writes to it are dropped.

---
 rtl/alu_writeback.sv | 159 +++++++++++++++
 tb/tb_alu_writeback.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
`default_nettype none
// ============================================================================
// Module   : alu_writeback
// Purpose  : Writeback stage behind the 32-bit ALU. Buffers 64-bit results in
//            a 2-entry FIFO. MUL/DIV results retire into the HI/LO registers.
//            All other results go to the register-file write port with a
//            write/acknowledge handshake. Writes to register 0 are dropped.
// Ports    : Clock, Clear (async active-low)
//            in_valid/in_ready/in_control/in_dest/in_result : ALU result in
//            rf_we/rf_addr/rf_data/rf_ack                    : RF write port
//            hi_out/lo_out : HI/LO registers
//            busy          : FIFO non-empty
//            fwd_valid/fwd_addr/fwd_data : operand bypass (optional)
// Config   : define ALU_WB_FORWARD_EN to add the bypass outputs
// Revision : 1.0 - initial release
// ============================================================================
module alu_writeback #(
  parameter int         DATA_W = 32,
  parameter int         ADDR_W = 4,
  parameter logic [4:0] MUL_OP = 5'b01110,
  parameter logic [4:0] DIV_OP = 5'b01111
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4:0]          in_control,
  input  logic [ADDR_W-1:0]   in_dest,
  input  logic [2*DATA_W-1:0] in_result,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_addr,
  output logic [DATA_W-1:0]   rf_data,
  input  logic                rf_ack,
  output logic [DATA_W-1:0]   hi_out,
  output logic [DATA_W-1:0]   lo_out,
  output logic                busy
`ifdef ALU_WB_FORWARD_EN
  ,
  output logic                fwd_valid,
  output logic [ADDR_W-1:0]   fwd_addr,
  output logic [DATA_W-1:0]   fwd_data
`endif
);

  // FIFO storage (2 entries) and bookkeeping
  logic [4:0]          r_ctrl [2];
  logic [ADDR_W-1:0]   r_dest [2];
  logic [2*DATA_W-1:0] r_res  [2];
  logic                r_wptr;
  logic                r_rptr;
  logic [1:0]          r_count;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;

  logic                w_nonempty;
  logic                w_push;
  logic                w_pop;
  logic                w_head_hilo;
  logic                w_head_zero;
  logic                w_head_gpr;
  logic [4:0]          w_head_ctrl;
  logic [ADDR_W-1:0]   w_head_dest;
  logic [2*DATA_W-1:0] w_head_res;

  assign w_nonempty  = (r_count != 2'd0);
  assign in_ready    = (r_count < 2'd2);
  assign w_push      = in_valid & in_ready;

  assign w_head_ctrl = r_ctrl[r_rptr];
  assign w_head_dest = r_dest[r_rptr];
  assign w_head_res  = r_res[r_rptr];

  // Head classification; only meaningful while the FIFO holds something
  assign w_head_hilo = w_nonempty & ((w_head_ctrl == MUL_OP) | (w_head_ctrl == DIV_OP));
  assign w_head_zero = w_nonempty & ~w_head_hilo & (w_head_dest == '0);
  assign w_head_gpr  = w_nonempty & ~w_head_hilo & (w_head_dest != '0);

  // HILO and ZERO retire unconditionally; GPR waits for the RF to accept.
  // rf_ack is only consulted when rf_we is high.
  assign w_pop = w_head_hilo | w_head_zero | (w_head_gpr & rf_ack);

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_ctrl[0] <= '0;
      r_ctrl[1] <= '0;
      r_dest[0] <= '0;
      r_dest[1] <= '0;
      r_res[0]  <= '0;
      r_res[1]  <= '0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_count   <= 2'd0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      if (w_push) begin
        r_ctrl[r_wptr] <= in_control;
        r_dest[r_wptr] <= in_dest;
        r_res[r_wptr]  <= in_result;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_head_hilo) begin
        r_hi <= w_head_res[2*DATA_W-1:DATA_W];
        r_lo <= w_head_res[DATA_W-1:0];
      end
    end
  end

  // Outputs decode purely from FIFO state; nothing from in_* reaches them
  assign rf_we   = w_head_gpr;
  assign rf_addr = w_nonempty ? w_head_dest : '0;
  assign rf_data = w_nonempty ? w_head_res[DATA_W-1:0] : '0;
  assign hi_out  = r_hi;
  assign lo_out  = r_lo;
  assign busy    = w_nonempty;

`ifdef ALU_WB_FORWARD_EN
  // Youngest entry sits just behind the write pointer; the older one (only
  // present when full) sits at the read pointer.
  logic w_young_idx;
  logic w_young_ok;
  logic w_old_ok;

  assign w_young_idx = ~r_wptr;
  assign w_young_ok  = w_nonempty
                     & (r_ctrl[w_young_idx] != MUL_OP)
                     & (r_ctrl[w_young_idx] != DIV_OP)
                     & (r_dest[w_young_idx] != '0);
  assign w_old_ok    = (r_count == 2'd2)
                     & (r_ctrl[r_rptr] != MUL_OP)
                     & (r_ctrl[r_rptr] != DIV_OP)
                     & (r_dest[r_rptr] != '0);

  always_comb begin
    fwd_valid = 1'b0;
    fwd_addr  = '0;
    fwd_data  = '0;
    if (w_young_ok) begin
      fwd_valid = 1'b1;
      fwd_addr  = r_dest[w_young_idx];
      fwd_data  = r_res[w_young_idx][DATA_W-1:0];
    end else if (w_old_ok) begin
      fwd_valid = 1'b1;
      fwd_addr  = r_dest[r_rptr];
      fwd_data  = r_res[r_rptr][DATA_W-1:0];
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_writeback
// Purpose  : Directed self-checking bench for alu_writeback. Covers reset,
//            GPR write, HILO update, back-to-back writes, backpressure,
//            zero-register drop, reset mid-handshake and (when
//            ALU_WB_FORWARD_EN is defined) forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_writeback;

  localparam logic [4:0] MUL_C = 5'b01110;
  localparam logic [4:0] ADD_C = 5'b00011;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_control;
  logic [3:0]  in_dest;
  logic [63:0] in_result;
  logic        rf_we;
  logic [3:0]  rf_addr;
  logic [31:0] rf_data;
  logic        rf_ack;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
`ifdef ALU_WB_FORWARD_EN
  logic        fwd_valid;
  logic [3:0]  fwd_addr;
  logic [31:0] fwd_data;
`endif

  int checks   = 0;
  int failures = 0;

  alu_writeback dut (
    .Clock      (Clock),
    .Clear      (Clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_control (in_control),
    .in_dest    (in_dest),
    .in_result  (in_result),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .rf_ack     (rf_ack),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .busy       (busy)
`ifdef ALU_WB_FORWARD_EN
    ,
    .fwd_valid  (fwd_valid),
    .fwd_addr   (fwd_addr),
    .fwd_data   (fwd_data)
`endif
  );

  always #5 Clock = ~Clock;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] c, input logic [3:0] d,
                       input logic [63:0] r);
    in_valid   = v;
    in_control = c;
    in_dest    = d;
    in_result  = r;
  endtask

  task automatic test_reset();
    Clear  = 1'b0;
    rf_ack = 1'b0;
    drive(1'b0, 5'd0, 4'd0, 64'd0);
    #12;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if ({rf_we, rf_addr, rf_data, busy} !== 38'd0) begin
      failures++; $display("FAIL reset_rf got=%b/%h/%h/%b exp=0", rf_we, rf_addr, rf_data, busy);
    end
    checks++;
    if ({hi_out, lo_out} !== 64'd0) begin failures++; $display("FAIL reset_hilo got=%h/%h exp=0", hi_out, lo_out); end
`ifdef ALU_WB_FORWARD_EN
    checks++;
    if ({fwd_valid, fwd_addr, fwd_data} !== 37'd0) begin
      failures++; $display("FAIL reset_fwd got=%b/%h/%h exp=0", fwd_valid, fwd_addr, fwd_data);
    end
`endif
    @(negedge Clock);
    Clear = 1'b1;
    tick();
  endtask

  task automatic test_gpr_write();
    rf_ack = 1'b1;
    drive(1'b1, ADD_C, 4'd3, 64'h0000_0000_0000_0008);
    tick();
    drive(1'b0, 5'd0, 4'd0, 64'd0);
    checks++;
    if ({rf_we, rf_addr, rf_data} !== {1'b1, 4'd3, 32'h8}) begin
      failures++; $display("FAIL gpr_write got=%b/%h/%h exp=1/3/00000008", rf_we, rf_addr, rf_data);
    end
    tick();
    checks++;
    if ({rf_we, busy} !== 2'b00) begin
      failures++; $display("FAIL gpr_one_cycle got=we%b busy%b exp=we0 busy0", rf_we, busy);
    end
  endtask

  task automatic test_hilo();
    rf_ack = 1'b1;
    drive(1'b1, MUL_C, 4'd9, 64'h0000_0001_0000_0010);
    tick();
    drive(1'b0, 5'd0, 4'd0, 64'd0);
    checks++;
    if ({rf_we, hi_out, lo_out} !== {1'b0, 32'h0, 32'h0}) begin
      failures++; $display("FAIL hilo_early got=%b/%h/%h exp=0/0/0", rf_we, hi_out, lo_out);
    end
    tick();
    checks++;
    if ({rf_we, hi_out, lo_out} !== {1'b0, 32'h1, 32'h10}) begin
      failures++; $display("FAIL hilo_update got=%b/%h/%h exp=0/00000001/00000010", rf_we, hi_out, lo_out);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL hilo_pop got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    rf_ack = 1'b1;
    drive(1'b1, ADD_C, 4'd4, 64'h44);
    tick();
    drive(1'b1, ADD_C, 4'd5, 64'h55);
    checks++;
    if ({rf_we, rf_addr, rf_data} !== {1'b1, 4'd4, 32'h44}) begin
      failures++; $display("FAIL b2b_first got=%b/%h/%h exp=1/4/00000044", rf_we, rf_addr, rf_data);
    end
    tick();
    drive(1'b0, 5'd0, 4'd0, 64'd0);
    checks++;
    if ({rf_we, rf_addr, rf_data} !== {1'b1, 4'd5, 32'h55}) begin
      failures++; $display("FAIL b2b_second got=%b/%h/%h exp=1/5/00000055", rf_we, rf_addr, rf_data);
    end
    tick();
    checks++;
    if ({rf_we, busy} !== 2'b00) begin failures++; $display("FAIL b2b_drain got=%b%b exp=00", rf_we, busy); end
  endtask

  task automatic test_backpressure();
    logic [3:0]  wa [8];
    logic [31:0] wd [8];
    int          nwr;
    logic        pushed;
    nwr    = 0;
    rf_ack = 1'b0;
    drive(1'b1, ADD_C, 4'd1, 64'h11);
    tick();
    drive(1'b1, ADD_C, 4'd2, 64'h22);
    tick();
    drive(1'b1, ADD_C, 4'd3, 64'h33);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%b exp=0", in_ready); end
    tick();
    tick();
    checks++;
    if ({in_ready, rf_we, rf_addr, rf_data, busy} !== {1'b0, 1'b1, 4'd1, 32'h11, 1'b1}) begin
      failures++; $display("FAIL bp_stall got=%b/%b/%h/%h/%b exp=0/1/1/00000011/1",
                           in_ready, rf_we, rf_addr, rf_data, busy);
    end
    rf_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (rf_we && rf_ack && nwr < 8) begin
        wa[nwr] = rf_addr;
        wd[nwr] = rf_data;
        nwr++;
      end
      pushed = in_valid & in_ready;
      tick();
      if (pushed) drive(1'b0, 5'd0, 4'd0, 64'd0);
    end
    checks++;
    if (nwr != 3) begin
      failures++; $display("FAIL bp_count got=%0d exp=3", nwr);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wa[i] !== 4'(i + 1) || wd[i] !== 32'(17 * (i + 1))) begin
          failures++; $display("FAIL bp_order[%0d] got=%h/%h exp=%h/%h", i, wa[i], wd[i], 4'(i + 1), 32'(17 * (i + 1)));
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", busy); end
  endtask

  task automatic test_zero_reg();
    rf_ack = 1'b0;
    drive(1'b1, ADD_C, 4'd0, 64'hDEAD);
    tick();
    drive(1'b0, 5'd0, 4'd0, 64'd0);
    checks++;
    if ({rf_we, busy} !== 2'b01) begin failures++; $display("FAIL zero_head got=we%b busy%b exp=we0 busy1", rf_we, busy); end
    tick();
    checks++;
    if ({rf_we, busy} !== 2'b00) begin failures++; $display("FAIL zero_pop got=we%b busy%b exp=we0 busy0", rf_we, busy); end
  endtask

  task automatic test_reset_mid();
    rf_ack = 1'b0;
    drive(1'b1, MUL_C, 4'd0, 64'h0000_0002_0000_0003);
    tick();
    drive(1'b1, ADD_C, 4'd7, 64'h77);
    tick();
    drive(1'b0, 5'd0, 4'd0, 64'd0);
    checks++;
    if ({hi_out, lo_out, rf_we, rf_addr} !== {32'h2, 32'h3, 1'b1, 4'd7}) begin
      failures++; $display("FAIL mid_setup got=%h/%h/%b/%h exp=2/3/1/7", hi_out, lo_out, rf_we, rf_addr);
    end
    #3;
    Clear = 1'b0;
    #1;
    checks++;
    if ({in_ready, rf_we, rf_addr, rf_data, hi_out, lo_out, busy} !== {1'b1, 102'd0}) begin
      failures++; $display("FAIL mid_reset got=%b/%b/%h/%h/%h/%h/%b exp=1/0/0/0/0/0/0",
                           in_ready, rf_we, rf_addr, rf_data, hi_out, lo_out, busy);
    end
    @(negedge Clock);
    Clear  = 1'b1;
    rf_ack = 1'b1;
    tick();
    checks++;
    if ({rf_we, busy} !== 2'b00) begin failures++; $display("FAIL mid_discard got=%b%b exp=00", rf_we, busy); end
  endtask

`ifdef ALU_WB_FORWARD_EN
  task automatic test_forward();
    rf_ack = 1'b0;
    drive(1'b1, ADD_C, 4'd5, 64'h55);
    tick();
    drive(1'b1, ADD_C, 4'd6, 64'h66);
    checks++;
    if ({fwd_valid, fwd_addr, fwd_data} !== {1'b1, 4'd5, 32'h55}) begin
      failures++; $display("FAIL fwd_one got=%b/%h/%h exp=1/5/00000055", fwd_valid, fwd_addr, fwd_data);
    end
    tick();
    drive(1'b0, 5'd0, 4'd0, 64'd0);
    checks++;
    if ({fwd_valid, fwd_addr, fwd_data} !== {1'b1, 4'd6, 32'h66}) begin
      failures++; $display("FAIL fwd_young got=%b/%h/%h exp=1/6/00000066", fwd_valid, fwd_addr, fwd_data);
    end
    rf_ack = 1'b1;
    tick();
    tick();
    checks++;
    if ({fwd_valid, busy} !== 2'b00) begin failures++; $display("FAIL fwd_empty got=%b%b exp=00", fwd_valid, busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_gpr_write();
    test_hilo();
    test_back_to_back();
    test_backpressure();
    test_zero_reg();
`ifdef ALU_WB_FORWARD_EN
    test_forward();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
